pulse_sequencer: RTL
====================

PULSE_SEQUENCER -- requirements
Module: pulse_sequencer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- COUNTBW, 20, width of the high/low phase counts.
- DEPTH, 4, profile table entries.
- ADDRW, 2, table address width, equal to log2(DEPTH).
- REPW, 8, width of the repeat count.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- CLK, in, 1, single clock for all logic.
- RST, in, 1, asynchronous, active-high reset.
- locked, in, 1, clock-good qualifier; low forces idle.
- start, in, 1, begin a sequence (level sampled in IDLE).
- abort, in, 1, stop the running sequence.
- loop, in, 1, restart at entry 0 after the last entry.
- num_entries, in, ADDRW+1, entries to run (1..DEPTH).
- wr_en, in, 1, table write strobe.
- wr_addr, in, ADDRW, table write address.
- wr_high, in, COUNTBW, high-phase cycle count.
- wr_low, in, COUNTBW, low-phase cycle count.
- wr_reps, in, REPW, pulses per entry.
- so, out, 1, generated pulse train.
- busy, out, 1, sequence active.
- done, out, 1, one-cycle end-of-sequence strobe.
- cur_entry, out, ADDRW, active table index.
- cur_rep, out, REPW, completed pulses in the active entry.

Function
REQ-003 The block SHALL hold a DEPTH-entry table of {high, low, reps}; wr_en writes entry wr_addr on the CLK edge, and writes are accepted in every state.
REQ-004 The block SHALL implement states IDLE, LOAD, HIGH, LOW and DONE, with all outputs registered.
REQ-005 In IDLE, with locked=1, start=1 and 1<=num_entries<=DEPTH, the block SHALL go to LOAD with cur_entry=0 and cur_rep=0; a start with num_entries=0 or num_entries>DEPTH SHALL be ignored.
REQ-006 LOAD SHALL latch the table entry at cur_entry into working registers, so a write to that entry during HIGH/LOW takes effect only at the next LOAD of it.
REQ-007 From LOAD, an entry with high=0 or reps=0 SHALL be skipped: the block advances to the next entry in one cycle without entering HIGH.
REQ-008 Otherwise LOAD SHALL go to HIGH, and HIGH SHALL last exactly high cycles.
REQ-009 HIGH SHALL go to LOW, which lasts exactly low cycles; if low=0, HIGH SHALL go directly to the next pulse or entry, so so stays 1 across the boundary.
REQ-010 At the end of each pulse, cur_rep SHALL increment; if cur_rep+1<reps the block SHALL re-enter HIGH with no gap cycle, else it SHALL advance the entry.
REQ-011 Entry advance SHALL go to LOAD with cur_entry+1 if cur_entry+1<num_entries; else to LOAD with entry 0 if loop=1; else to DONE.
REQ-012 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-013 so SHALL be 1 exactly in cycles where the state is HIGH.
REQ-014 busy SHALL be 1 in LOAD, HIGH and LOW, and 0 in IDLE and DONE.
REQ-015 Latency: with start sampled high at edge k, LOAD SHALL be registered at k+1 and so SHALL rise at edge k+2.
REQ-016 With abort=1 in LOAD, HIGH or LOW, the block SHALL go to DONE next cycle with so=0; abort SHALL be ignored in IDLE and DONE.
REQ-017 If abort and a natural phase end coincide, abort SHALL win.
REQ-018 With locked=0, the block SHALL go to IDLE next cycle, and so, busy, done, cur_entry, cur_rep and the phase counter SHALL clear; the table SHALL be retained, and done SHALL not pulse.
REQ-019 Phase counters SHALL be COUNTBW bits and compare against count-1 with no overflow; a count of 2^COUNTBW-1 SHALL be valid.
REQ-020 A start held high through DONE SHALL restart the sequence from IDLE on the following cycle.

Reset
REQ-021 RST=1 SHALL asynchronously force IDLE and zero every output, the counters, and all table entries.
REQ-022 After RST deasserts, the block SHALL act on start only at a rising CLK edge with locked=1.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Entry0={3,2,2}, num_entries=1, start: so=1 for 3 cycles, 0 for 2, 1 for 3, 0 for 2; then done for 1 cycle, busy low.
- Entries {2,1,1},{0,5,3},{1,0,2}, num_entries=3: pulse 2H/1L, entry 1 skipped in one LOAD cycle, then so high for 2 consecutive cycles; done.
- loop=1, entry0={1,1,1}, num_entries=1: so toggles 1,0 with a LOAD gap between pulses (1,0,0,1,0,0...); assert abort in HIGH: so=0 next cycle, done=1.
- locked deasserted in the middle of LOW: next cycle IDLE, all outputs 0, no done; reassert locked and start: the sequence replays from entry 0 with the retained table.
- RST asserted asynchronously in the middle of HIGH: so drops without a clock edge; after release, start with num_entries=1 and zeroed table: skip, then done, with so never high.
- Write entry0 high=4 while entry0 runs with high=2 and reps=2, loop=0: both pulses use high=2; a rerun uses 4.

Source files
------------

// File: rtl/pulse_sequencer.sv
// Table-driven pulse train generator: each profile entry emits `reps` pulses of
// `high` cycles on followed by `low` cycles off, walking num_entries entries.
module pulse_sequencer #(
    parameter int COUNTBW = 20,
    parameter int DEPTH   = 4,
    parameter int ADDRW   = 2,
    parameter int REPW    = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               locked,
    input  logic               start,
    input  logic               abort,
    input  logic               loop,
    input  logic [ADDRW:0]     num_entries,
    input  logic               wr_en,
    input  logic [ADDRW-1:0]   wr_addr,
    input  logic [COUNTBW-1:0] wr_high,
    input  logic [COUNTBW-1:0] wr_low,
    input  logic [REPW-1:0]    wr_reps,
    output logic               so,
    output logic               busy,
    output logic               done,
    output logic [ADDRW-1:0]   cur_entry,
    output logic [REPW-1:0]    cur_rep
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HIGH,
        S_LOW,
        S_DONE
    } state_t;

    state_t state_reg, state_next;

    logic [COUNTBW-1:0] tbl_high [DEPTH];
    logic [COUNTBW-1:0] tbl_low  [DEPTH];
    logic [REPW-1:0]    tbl_reps [DEPTH];

    logic [COUNTBW-1:0] high_reg, low_reg;
    logic [REPW-1:0]    reps_reg;
    logic [COUNTBW-1:0] cnt_reg, cnt_next;
    logic [ADDRW-1:0]   entry_reg, entry_next;
    logic [REPW-1:0]    rep_reg, rep_next;
    logic               so_reg, so_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;

    logic [COUNTBW-1:0] sel_high;
    logic [REPW-1:0]    sel_reps;
    logic [ADDRW:0]     entry_inc;
    logic [REPW:0]      rep_inc;
    logic               start_ok;
    logic               last_entry;
    logic               pulse_end;
    logic               advance;

    // Each table entry is its own register so reset can clear the whole profile.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tbl
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    tbl_high[gi] <= '0;
                    tbl_low[gi]  <= '0;
                    tbl_reps[gi] <= '0;
                end else if (wr_en && wr_addr == ADDRW'(gi)) begin
                    tbl_high[gi] <= wr_high;
                    tbl_low[gi]  <= wr_low;
                    tbl_reps[gi] <= wr_reps;
                end
            end
        end
    endgenerate

    assign sel_high   = tbl_high[entry_reg];
    assign sel_reps   = tbl_reps[entry_reg];
    assign entry_inc  = {1'b0, entry_reg} + (ADDRW+1)'(1);
    assign rep_inc    = {1'b0, rep_reg} + (REPW+1)'(1);
    assign last_entry = !(entry_inc < num_entries);
    assign start_ok   = start && (num_entries != '0) && (num_entries <= (ADDRW+1)'(DEPTH));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= S_IDLE;
            high_reg  <= '0;
            low_reg   <= '0;
            reps_reg  <= '0;
            cnt_reg   <= '0;
            entry_reg <= '0;
            rep_reg   <= '0;
            so_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            entry_reg <= entry_next;
            rep_reg   <= rep_next;
            so_reg    <= so_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            // Snapshot so later table writes only affect the next LOAD of this entry.
            if (state_reg == S_LOAD) begin
                high_reg <= sel_high;
                low_reg  <= tbl_low[entry_reg];
                reps_reg <= sel_reps;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        entry_next = entry_reg;
        rep_next   = rep_reg;
        pulse_end  = 1'b0;
        advance    = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start_ok) begin
                    state_next = S_LOAD;
                    entry_next = '0;
                    rep_next   = '0;
                    cnt_next   = '0;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_next = S_DONE;
                end else if (sel_high == '0 || sel_reps == '0) begin
                    advance = 1'b1;
                end else begin
                    state_next = S_HIGH;
                    cnt_next   = '0;
                end
            end
            S_HIGH: begin
                if (abort) begin
                    state_next = S_DONE;
                    cnt_next   = '0;
                end else if (cnt_reg == high_reg - COUNTBW'(1)) begin
                    if (low_reg == '0) begin
                        pulse_end = 1'b1;
                    end else begin
                        state_next = S_LOW;
                        cnt_next   = '0;
                    end
                end else begin
                    cnt_next = cnt_reg + COUNTBW'(1);
                end
            end
            S_LOW: begin
                if (abort) begin
                    state_next = S_DONE;
                    cnt_next   = '0;
                end else if (cnt_reg == low_reg - COUNTBW'(1)) begin
                    pulse_end = 1'b1;
                end else begin
                    cnt_next = cnt_reg + COUNTBW'(1);
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        // Back-to-back pulses re-enter HIGH directly, keeping so continuous when low=0.
        if (pulse_end) begin
            cnt_next = '0;
            if (rep_inc < {1'b0, reps_reg}) begin
                state_next = S_HIGH;
                rep_next   = rep_inc[REPW-1:0];
            end else begin
                advance = 1'b1;
            end
        end

        if (advance) begin
            rep_next = '0;
            cnt_next = '0;
            if (!last_entry) begin
                state_next = S_LOAD;
                entry_next = entry_inc[ADDRW-1:0];
            end else if (loop) begin
                state_next = S_LOAD;
                entry_next = '0;
            end else begin
                state_next = S_DONE;
            end
        end

        // Losing the clock qualifier drops straight to idle without a done strobe.
        if (!locked) begin
            state_next = S_IDLE;
            entry_next = '0;
            rep_next   = '0;
            cnt_next   = '0;
        end
    end

    always_comb begin
        so_next   = (state_next == S_HIGH);
        busy_next = (state_next == S_LOAD) || (state_next == S_HIGH) || (state_next == S_LOW);
        done_next = (state_next == S_DONE);
    end

    assign so        = so_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign cur_entry = entry_reg;
    assign cur_rep   = rep_reg;

endmodule
